// File: rtl/mag_com_sort_ctrl.sv
// Block sorter: loads DEPTH words, bubble-sorts them in place through an external
// magnitude comparator (one compare per cycle), then drains them smallest first.
module mag_com_sort_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic [1:0]       cmp_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, idx, pass;
  logic [PW-1:0]    idx_p1, last_idx;
  logic             swapped;
  logic             load_acc, drain_acc, do_swap, cmp_bad;
  logic             pass_end, swapped_any, sort_done;

  assign idx_p1      = idx + PW'(1);
  assign last_idx    = PW'(DEPTH - 2) - pass;
  assign load_acc    = (state == LOAD) && in_valid;
  assign drain_acc   = (state == DRAIN) && out_ready;
  assign do_swap     = (state == SORT) && (cmp_f == 2'b10);
  assign cmp_bad     = (state == SORT) && (cmp_f == 2'b11);
  assign pass_end    = (idx == last_idx);
  // The swap decided this cycle counts toward the early-exit test.
  assign swapped_any = swapped | do_swap;
  assign sort_done   = !swapped_any || (pass == PW'(DEPTH - 2));
  assign out_data    = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    cmp_a     = '0;
    cmp_b     = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_ptr == PW'(DEPTH - 1))) state_nxt = SORT;
      end
      SORT: begin
        busy  = 1'b1;
        cmp_a = mem[idx];
        cmp_b = mem[idx_p1];
        if (pass_end && sort_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (rd_ptr == PW'(DEPTH - 1))) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (load_acc) begin
        if (wr_ptr == PW'(DEPTH - 1)) begin
          wr_ptr  <= '0;
          idx     <= '0;
          pass    <= '0;
          swapped <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr + PW'(1);
        end
      end
      if (cmp_bad) err <= 1'b1;
      if (state == SORT) begin
        if (pass_end) begin
          if (sort_done) begin
            rd_ptr <= '0;
          end else begin
            pass    <= pass + PW'(1);
            idx     <= '0;
            swapped <= 1'b0;
          end
        end else begin
          idx     <= idx_p1;
          swapped <= swapped_any;
        end
      end
      if (drain_acc) begin
        if (rd_ptr == PW'(DEPTH - 1)) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // Word storage carries no reset; only the sequencer state does.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem[wr_ptr] <= in_data;
    end else if (do_swap) begin
      mem[idx]    <= mem[idx_p1];
      mem[idx_p1] <= mem[idx];
    end
  end

endmodule

// File: tb/tb_mag_com_sort_ctrl.sv
// Scoreboard bench for mag_com_sort_ctrl with a behavioural comparator model.
module tb_mag_com_sort_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid, busy, err;
  logic [WIDTH-1:0] cmp_a, cmp_b, out_data;
  logic [1:0]       cmp_f;

  logic             force_err = 1'b0;
  bit               rand_rdy = 1'b0;
  int               n_total = 0;
  int               n_bad = 0;
  int               busy_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             stalled = 1'b0;
  logic [WIDTH-1:0] held = '0;

  mag_com_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_f(cmp_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (force_err)          cmp_f = 2'b11;
    else if (cmp_a < cmp_b) cmp_f = 2'b01;
    else if (cmp_a > cmp_b) cmp_f = 2'b10;
    else                    cmp_f = 2'b00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each transfer, checks hold while stalled.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (out_valid) begin
      if (stalled) chk("hold", 32'(out_data), 32'(held));
      if (out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF);
        else                   chk("drain", 32'(out_data), 32'(exp_q.pop_front()));
      end else begin
        stalled = 1'b1;
        held    = out_data;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic push_exp(input logic [31:0] e);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(e[4*i +: 4]);
  endtask

  task automatic load_block(input logic [31:0] d, input bit ferr);
    @(posedge clk);
    #1;
    busy_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = d[4*i +: 4];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (ferr) begin
      force_err = 1'b1;
      @(posedge clk);
      #1;
      force_err = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cmp_a", 32'(cmp_a), 0);
    chk("rst_cmp_b", 32'(cmp_b), 0);

    push_exp(32'h87654321);
    load_block(32'h87654321, 1'b0);
    wait_drain("sorted");
    chk("sorted_busy", 32'(busy_cnt), 7);

    push_exp(32'hFEDCBA98);
    load_block(32'h89ABCDEF, 1'b0);
    wait_drain("reverse");
    chk("reverse_busy", 32'(busy_cnt), 28);

    rand_rdy = 1'b1;
    push_exp(32'hF5553300);
    load_block(32'h50F30535, 1'b0);
    wait_drain("dups");
    rand_rdy = 1'b0;
    chk("dups_err", 32'(err), 0);

    // The forced first compare would have swapped 2,1; it must be left alone.
    push_exp(32'h87654312);
    load_block(32'h87654312, 1'b1);
    wait_drain("errblk");
    chk("errblk_busy", 32'(busy_cnt), 7);
    chk("errblk_err", 32'(err), 1);

    push_exp(32'h87654321);
    load_block(32'h12345678, 1'b0);
    wait_drain("after_err");
    chk("err_sticky", 32'(err), 1);

    load_block(32'h89ABCDEF, 1'b0);
    repeat (10) @(posedge clk);
    pulse_reset();
    @(negedge clk);
    chk("msort_busy", 32'(busy), 0);
    chk("msort_in_ready", 32'(in_ready), 1);
    chk("msort_err", 32'(err), 0);
    push_exp(32'hF5553300);
    load_block(32'h50F30535, 1'b0);
    wait_drain("msort_new");

    push_exp(32'hFEDCBA98);
    load_block(32'h89ABCDEF, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() <= 5) break;
    end
    chk("mdrain_reach", 32'(exp_q.size() <= 5), 1);
    pulse_reset();
    @(negedge clk);
    chk("mdrain_out_valid", 32'(out_valid), 0);
    chk("mdrain_in_ready", 32'(in_ready), 1);
    push_exp(32'h87654321);
    load_block(32'h18273645, 1'b0);
    wait_drain("mdrain_new");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
